// File: rtl/memory_writeback.sv
// MEM/WB stage: runs lw/sw against a req/ack data memory with a timeout, and
// drives the write-back port toward decode. Stalls upstream while an access is outstanding.
module memory_writeback #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_valid,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_ALUout,
  input  logic [31:0] XM_MD,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [4:0]  MW_RD,
  output logic [31:0] MDR,
  output logic [31:0] MW_ALUout,
  output logic        mem_err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [DATA_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [REG_W-1:0]    lat_rd_q, lat_rd_d;
  logic                lat_memtoreg_q, lat_memtoreg_d;
  logic                lat_regwrite_q, lat_regwrite_d;
  logic                mw_memtoreg_q, mw_memtoreg_d;
  logic                mw_regwrite_q, mw_regwrite_d;
  logic [REG_W-1:0]    mw_rd_q, mw_rd_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   mw_alu_q, mw_alu_d;
  logic                mem_err_q, mem_err_d;

  logic memop;
  logic misaligned;
  logic timeout;

  assign memop      = XM_valid & (XM_MemRead | XM_MemWrite);
  assign misaligned = (XM_ALUout[1:0] != 2'b00);
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT));

  // Gated by rst so stall reads 0 while reset is asserted, whatever XM_* shows.
  assign stall = rst & (((state_q == S_IDLE) & memop & ~misaligned) |
                        ((state_q == S_WAIT) & ~dm_ack & ~timeout));

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    dm_addr_d      = dm_addr_q;
    dm_wdata_d     = dm_wdata_q;
    lat_rd_d       = lat_rd_q;
    lat_memtoreg_d = lat_memtoreg_q;
    lat_regwrite_d = lat_regwrite_q;
    mw_memtoreg_d  = mw_memtoreg_q;
    mw_regwrite_d  = 1'b0;
    mw_rd_d        = mw_rd_q;
    mdr_d          = mdr_q;
    mw_alu_d       = mw_alu_q;
    mem_err_d      = mem_err_q;

    case (state_q)
      S_IDLE: begin
        if (XM_valid && !memop) begin
          mw_rd_d       = XM_RD;
          mw_alu_d      = XM_ALUout;
          mw_memtoreg_d = 1'b0;
          mw_regwrite_d = XM_RegWrite & (XM_RD != REG_W'(0));
        end else if (memop && misaligned) begin
          mem_err_d = 1'b1;
        end else if (memop) begin
          state_d        = S_WAIT;
          cnt_d          = '0;
          dm_req_d       = 1'b1;
          dm_we_d        = XM_MemWrite & ~XM_MemRead;
          dm_addr_d      = XM_ALUout;
          dm_wdata_d     = XM_MD;
          lat_rd_d       = XM_RD;
          lat_memtoreg_d = XM_MemtoReg;
          lat_regwrite_d = XM_RegWrite;
        end
      end
      S_WAIT: begin
        // dm_addr_q doubles as the latched ALU result; ack beats timeout.
        if (dm_ack) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          dm_req_d      = 1'b0;
          if (!dm_we_q) mdr_d = dm_rdata;
          mw_rd_d       = lat_rd_q;
          mw_alu_d      = dm_addr_q;
          mw_memtoreg_d = lat_memtoreg_q;
          mw_regwrite_d = lat_regwrite_q & (lat_rd_q != REG_W'(0)) & ~dm_we_q;
        end else if (timeout) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          dm_req_d  = 1'b0;
          mem_err_d = 1'b1;
          mdr_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= '0;
      dm_wdata_q     <= '0;
      lat_rd_q       <= '0;
      lat_memtoreg_q <= 1'b0;
      lat_regwrite_q <= 1'b0;
      mw_memtoreg_q  <= 1'b0;
      mw_regwrite_q  <= 1'b0;
      mw_rd_q        <= '0;
      mdr_q          <= '0;
      mw_alu_q       <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dm_req_q       <= dm_req_d;
      dm_we_q        <= dm_we_d;
      dm_addr_q      <= dm_addr_d;
      dm_wdata_q     <= dm_wdata_d;
      lat_rd_q       <= lat_rd_d;
      lat_memtoreg_q <= lat_memtoreg_d;
      lat_regwrite_q <= lat_regwrite_d;
      mw_memtoreg_q  <= mw_memtoreg_d;
      mw_regwrite_q  <= mw_regwrite_d;
      mw_rd_q        <= mw_rd_d;
      mdr_q          <= mdr_d;
      mw_alu_q       <= mw_alu_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign MW_MemtoReg = mw_memtoreg_q;
  assign MW_RegWrite = mw_regwrite_q;
  assign MW_RD       = mw_rd_q;
  assign MDR         = mdr_q;
  assign MW_ALUout   = mw_alu_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: ALU pass-through, lw/sw handshakes,
// timeout, misalignment and mid-access reset, with hand-computed expectations.
module tb_memory_writeback;

  localparam int unsigned TB_TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [4:0]  XM_RD;
  logic [31:0] XM_ALUout, XM_MD;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic        MW_MemtoReg, MW_RegWrite;
  logic [4:0]  MW_RD;
  logic [31:0] MDR, MW_ALUout;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  memory_writeback #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .XM_valid(XM_valid), .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite), .XM_RD(XM_RD),
    .XM_ALUout(XM_ALUout), .XM_MD(XM_MD),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
    .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD),
    .MDR(MDR), .MW_ALUout(MW_ALUout), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic mr,
                       input logic mw, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] md);
    XM_valid = v; XM_MemtoReg = m2r; XM_RegWrite = rw; XM_MemRead = mr;
    XM_MemWrite = mw; XM_RD = rd; XM_ALUout = alu; XM_MD = md;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    // Aligned lw presented during reset must not raise stall.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0);
    cyc();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_regwrite", 32'(MW_RegWrite), 32'd0);
    check("rst_mdr", MDR, 32'h0);
    check("rst_err", 32'(mem_err), 32'd0);
    bubble();
    @(negedge clk); rst = 1'b1;
    cyc();

    // 1: add RD=8 ALU=5
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 32'd5, 32'h0);
    check("add_stall", 32'(stall), 32'd0);
    cyc();
    check("add_rw", 32'(MW_RegWrite), 32'd1);
    check("add_rd", 32'(MW_RD), 32'd8);
    check("add_alu", MW_ALUout, 32'd5);
    check("add_m2r", 32'(MW_MemtoReg), 32'd0);
    bubble();
    cyc();
    check("bubble_rw", 32'(MW_RegWrite), 32'd0);
    check("bubble_rd_hold", 32'(MW_RD), 32'd8);

    // 2: lw RD=9 addr 0x40, ack in third WAIT cycle
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h40, 32'h0);
    check("lw_stall_idle", 32'(stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("lw_req", 32'(dm_req), 32'd1);
      check("lw_addr", dm_addr, 32'h40);
      check("lw_we", 32'(dm_we), 32'd0);
      check("lw_rw_wait", 32'(MW_RegWrite), 32'd0);
      if (k == 2) begin
        dm_ack = 1'b1; dm_rdata = 32'h1234; #1;
        check("lw_stall_ack", 32'(stall), 32'd0);
      end else begin
        check("lw_stall_wait", 32'(stall), 32'd1);
      end
    end
    bubble();
    cyc();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    check("lw_req_drop", 32'(dm_req), 32'd0);
    check("lw_mdr", MDR, 32'h1234);
    check("lw_m2r", 32'(MW_MemtoReg), 32'd1);
    check("lw_rw", 32'(MW_RegWrite), 32'd1);
    check("lw_rd", 32'(MW_RD), 32'd9);
    check("lw_alu", MW_ALUout, 32'h40);
    cyc();
    check("lw_rw_once", 32'(MW_RegWrite), 32'd0);

    // 3: sw addr 0x44 data 0xCAFE, ack in first WAIT cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h44, 32'hCAFE);
    cyc();
    check("sw_req", 32'(dm_req), 32'd1);
    check("sw_we", 32'(dm_we), 32'd1);
    check("sw_addr", dm_addr, 32'h44);
    check("sw_wdata", dm_wdata, 32'hCAFE);
    dm_ack = 1'b1; dm_rdata = 32'hBAD0; #1;
    check("sw_stall_ack", 32'(stall), 32'd0);
    bubble();
    cyc();
    dm_ack = 1'b0;
    check("sw_req_drop", 32'(dm_req), 32'd0);
    check("sw_rw", 32'(MW_RegWrite), 32'd0);
    check("sw_mdr_hold", MDR, 32'h1234);

    // 5: misaligned lw, then addi to r0
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h42, 32'h0);
    check("mis_stall", 32'(stall), 32'd0);
    cyc();
    check("mis_req", 32'(dm_req), 32'd0);
    check("mis_err", 32'(mem_err), 32'd1);
    check("mis_rw", 32'(MW_RegWrite), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd3, 32'h0);
    cyc();
    check("r0_rw", 32'(MW_RegWrite), 32'd0);
    check("r0_alu", MW_ALUout, 32'd3);
    check("err_sticky", 32'(mem_err), 32'd1);
    bubble();

    // Reset clears the sticky error
    @(negedge clk); rst = 1'b0; #1;
    check("rst_err_clear", 32'(mem_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    cyc();

    // 4: lw without ack times out after TIMEOUT+1 request cycles
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'h80, 32'h0);
    for (int k = 0; k <= int'(TB_TIMEOUT); k++) begin
      cyc();
      check("to_req", 32'(dm_req), 32'd1);
      check("to_stall", 32'(stall), (k == int'(TB_TIMEOUT)) ? 32'd0 : 32'd1);
    end
    cyc();
    check("to_req_drop", 32'(dm_req), 32'd0);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_mdr", MDR, 32'h0);
    check("to_rw", 32'(MW_RegWrite), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 32'd7, 32'h0);
    check("to_add_stall", 32'(stall), 32'd0);
    cyc();
    check("to_add_rw", 32'(MW_RegWrite), 32'd1);
    check("to_add_rd", 32'(MW_RD), 32'd11);
    check("to_add_alu", MW_ALUout, 32'd7);
    bubble();
    cyc();

    // 6: reset in WAIT cycle 2, then a stray ack
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h100, 32'h0);
    cyc();
    cyc();
    check("rw6_req_pre", 32'(dm_req), 32'd1);
    rst = 1'b0; #1;
    check("rw6_req", 32'(dm_req), 32'd0);
    check("rw6_stall", 32'(stall), 32'd0);
    check("rw6_rw", 32'(MW_RegWrite), 32'd0);
    check("rw6_rd", 32'(MW_RD), 32'd0);
    check("rw6_alu", MW_ALUout, 32'h0);
    bubble();
    @(negedge clk); rst = 1'b1;
    cyc();
    dm_ack = 1'b1; dm_rdata = 32'hDEAD; #1;
    check("stray_stall", 32'(stall), 32'd0);
    cyc();
    dm_ack = 1'b0;
    check("stray_rw", 32'(MW_RegWrite), 32'd0);
    check("stray_mdr", MDR, 32'h0);
    check("stray_req", 32'(dm_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
